// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered result and valid/ready handshakes on both sides.
// Build option ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter; otherwise shifts take 1 bit per cycle.
module alu_exec_unit #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      aluctr,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SLL  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h2;
  localparam logic [3:0] ALU_SLTU = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_AND  = 4'h7;
  localparam logic [3:0] ALU_SUB  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'hD;

  localparam logic [1:0] ST_IDLE  = 2'd0;
`ifndef ALU_FAST_SHIFT_EN
  localparam logic [1:0] ST_SHIFT = 2'd1;
`endif
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;

  function automatic logic [XLEN-1:0] calc(input logic [3:0] op,
                                           input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      ALU_ADD:  calc = a + b;
      ALU_SUB:  calc = a - b;
      ALU_SLT:  calc = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: calc = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  calc = a ^ b;
      ALU_OR:   calc = a | b;
      ALU_AND:  calc = a & b;
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL:  calc = a << sh;
      ALU_SRL:  calc = a >> sh;
      ALU_SRA:  calc = $unsigned($signed(a) >>> sh);
`else
      // Only reached with shamt 0; non-zero amounts go through the iterative path.
      ALU_SLL, ALU_SRL, ALU_SRA: calc = (sh == '0) ? a : '0;
`endif
      default:  calc = '0;
    endcase
  endfunction

`ifndef ALU_FAST_SHIFT_EN
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] step_in, step_out;
  logic [3:0]      step_op;
  logic            in_is_shift;
  logic [SHW-1:0]  in_shamt;

  assign in_is_shift = (aluctr == ALU_SLL) || (aluctr == ALU_SRL) || (aluctr == ALU_SRA);
  assign in_shamt    = op_b[SHW-1:0];
  assign step_op     = (state_q == ST_IDLE) ? aluctr : op_q;
  assign step_in     = (state_q == ST_IDLE) ? op_a : work_q;

  always_comb begin
    step_out = step_in;
    case (step_op)
      ALU_SLL: step_out = {step_in[XLEN-2:0], 1'b0};
      ALU_SRL: step_out = {1'b0, step_in[XLEN-1:1]};
      ALU_SRA: step_out = {step_in[XLEN-1], step_in[XLEN-1:1]};
      default: step_out = step_in;
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifndef ALU_FAST_SHIFT_EN
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifndef ALU_FAST_SHIFT_EN
          op_d = aluctr;
          if (in_is_shift && in_shamt != '0) begin
            // The accept edge performs the first 1-bit step, so cnt holds steps still to do.
            work_d = step_out;
            cnt_d  = in_shamt - SHW'(1);
            if (in_shamt == SHW'(1)) begin
              result_d = step_out;
              zero_d   = (step_out == '0);
              state_d  = ST_DONE;
            end else begin
              state_d  = ST_SHIFT;
            end
          end else begin
            result_d = calc(aluctr, op_a, op_b);
            zero_d   = (calc(aluctr, op_a, op_b) == '0);
            state_d  = ST_DONE;
          end
`else
          result_d = calc(aluctr, op_a, op_b);
          zero_d   = (calc(aluctr, op_a, op_b) == '0);
          state_d  = ST_DONE;
`endif
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      ST_SHIFT: begin
        work_d = step_out;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d = step_out;
          zero_d   = (step_out == '0);
          state_d  = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      zero_d   = zero_q;
`ifndef ALU_FAST_SHIFT_EN
      cnt_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
`ifndef ALU_FAST_SHIFT_EN
      op_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifndef ALU_FAST_SHIFT_EN
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases plus random operations scored against a reference model.
// Build with ALU_FAST_SHIFT_EN defined to match a fast-shift DUT build.
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SLL  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h2;
  localparam logic [3:0] ALU_SLTU = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_AND  = 4'h7;
  localparam logic [3:0] ALU_SUB  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'hD;

  logic            clk = 1'b0;
  logic            rst, in_valid, flush, out_ready;
  logic            in_ready, out_valid, zero, busy;
  logic [3:0]      aluctr;
  logic [XLEN-1:0] op_a, op_b, result;

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];
  logic [XLEN-1:0] last_res;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluctr(aluctr), .op_a(op_a), .op_b(op_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .busy(busy)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    int s;
    s = int'(b[4:0]);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_SLL:  return a << s;
      ALU_SRL:  return a >> s;
      ALU_SRA:  return a[31] ? ~((~a) >> s) : (a >> s);
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [XLEN-1:0] b);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    if ((op == ALU_SLL || op == ALU_SRL || op == ALU_SRA) && b[4:0] > 5'd1) return int'(b[4:0]);
    return 1;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    aluctr = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_res = '0;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input int bp);
    int lat;
    logic [XLEN-1:0] e;
    int el;
    exp_q.push_back(ref_alu(op, a, b));
    lat_q.push_back(exp_lat(op, b));
    @(negedge clk);
    check("acc_ready", in_ready, 1);
    in_valid = 1'b1; aluctr = op; op_a = a; op_b = b;
    @(negedge clk);
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; aluctr = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 80) begin
      check("shift_ready", in_ready, 0);
      @(negedge clk);
      lat++;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    check("latency", lat, el);
    check("result", result, e);
    check("zero", zero, (e == '0));
    last_res = e;
    repeat (bp) begin
      in_valid = 1'b1; aluctr = ALU_ADD;
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_hold", result, e);
      check("bp_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_ready", in_ready, 1);
  endtask

  initial begin
    logic [3:0] ops [10];
    logic [XLEN-1:0] flush_res;
    logic            flush_v5;
    ops = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};

    do_reset();
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);

    do_op(ALU_ADD, 32'd5, 32'd7, 0);
    do_op(ALU_SUB, 32'd3, 32'd5, 0);
    do_op(ALU_SUB, 32'd9, 32'd9, 0);
    do_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(ALU_SRA, 32'h8000_0000, 32'h24, 3);
    do_op(ALU_SLL, 32'h1234_5678, 32'h0, 0);
    do_op(ALU_SRL, 32'hF000_000F, 32'h1, 1);

    // Flush mid-shift: SLL 1 by 20 accepted, flush at cycle 5.
`ifdef ALU_FAST_SHIFT_EN
    flush_v5 = 1'b1; flush_res = 32'h0010_0000;
`else
    flush_v5 = 1'b0; flush_res = last_res;
`endif
    @(negedge clk);
    in_valid = 1'b1; aluctr = ALU_SLL; op_a = 32'd1; op_b = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("fl_c5_valid", out_valid, flush_v5);
    flush = 1'b1; in_valid = 1'b1; aluctr = ALU_ADD;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_ready", in_ready, 1);
    check("fl_valid", out_valid, 0);
    check("fl_busy", busy, 0);
    check("fl_result", result, flush_res);
    @(negedge clk);
    check("fl_ignored", out_valid, 0);
    do_op(ALU_ADD, 32'd1, 32'd1, 0);

    // Reset in the middle of SRL by 10.
    @(negedge clk);
    in_valid = 1'b1; aluctr = ALU_SRL; op_a = 32'hDEAD_BEEF; op_b = 32'd10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_valid", out_valid, 0);
    check("mr_result", result, 0);
    check("mr_zero", zero, 1);
    check("mr_ready", in_ready, 1);
    check("mr_busy", busy, 0);
    last_res = '0;

    do_op(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    do_op(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      logic [XLEN-1:0] a, b;
      op = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(9, 12)) : ops[$urandom_range(0, 9)];
      a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
      b  = ($urandom_range(0, 5) == 0) ? a : $urandom;
      do_op(op, a, b, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit alu_t operation code from the ALU control decoder, together with two register/immediate operands.
- Result is registered and returned over a valid/ready handshake.
- Shifts are computed iteratively, 1 bit per cycle, to save area.
- A compile-time option replaces the iterative shifter with a single-cycle barrel shifter.
- Sits between the decode/ALU-control stage and writeback/branch logic.

Parameters:
XLEN, 32, operand and result width; power of two, >= 8.
SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
in_valid  input  1  operation presented.
in_ready  output  1  unit can accept; high only in IDLE.
aluctr  input  4 (alu_t)  operation: ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND.
op_a  input  XLEN  operand A (shift source).
op_b  input  XLEN  operand B; bits [SHW-1:0] are the shift amount.
flush  input  1  synchronous kill of the in-flight operation.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
result  output  XLEN  registered result.
zero  output  1  result == 0; registered with result.
busy  output  1  high in SHIFT or DONE.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state = IDLE, result = 0, zero = 1, out_valid = 0, in_ready = 1, busy = 0, shift counter = 0.
- States:
  - IDLE: in_ready = 1.
  - SHIFT: in_ready = 0, out_valid = 0.
  - DONE: out_valid = 1, in_ready = 0.
- Accept: an operation is accepted on an edge where state == IDLE and in_valid = 1. aluctr, op_a and op_b are captured on that edge.
- Non-shift ops: result is computed and state goes IDLE -> DONE on the accept edge. out_valid is high the cycle after acceptance (latency 1).
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN; no flags besides zero.
  - SLT is a signed compare; SLTU is unsigned. The result is zero-extended 0 or 1.
- Shifts, iterative build:
  - shamt = op_b[SHW-1:0]; upper bits of op_b are ignored.
  - shamt == 0: result = op_a, go to DONE, latency 1.
  - shamt == k > 0: load the working register with op_a, counter = k, go to SHIFT.
  - Each SHIFT edge shifts by 1 and decrements the counter. SLL fills with 0, SRL fills with 0, SRA replicates the MSB.
  - When the counter reaches 0, go to DONE. out_valid is first high k cycles after the accept cycle.
- DONE: result and zero hold stable while out_ready = 0. On an edge with out_ready = 1, go to IDLE and drop out_valid. Maximum throughput is 1 op per 2 cycles; there is no accept in DONE.
- Illegal aluctr (unlisted encoding): result = 0, zero = 1, latency 1. It is never X.
- Flush:
  - On any edge with flush = 1 and rst = 0, go to IDLE, clear out_valid, clear the counter. result keeps its last value.
  - in_valid on the same edge is ignored.
  - flush has priority over acceptance and over out_ready.
- rst has priority over flush. Reset mid-SHIFT or mid-DONE discards the operation and restores reset values.
- Operand inputs may change freely after the accept edge; only the captured copies are used.

Optional Feature:
ALU_FAST_SHIFT_EN
- Defined: shifts use a combinational barrel shifter and complete with latency 1 like every other op. The SHIFT state and counter are not built, so busy only reflects DONE.
- Undefined: shifts use the iterative 1-bit-per-cycle path described above.
- All other behaviour is identical in both builds.

Test Plan:
- Arithmetic: ADD 5 + 7 accepted cycle 0 -> out_valid cycle 1, result 12, zero 0. SUB 3 - 5 -> 0xFFFFFFFE. SUB 9 - 9 -> result 0, zero 1.
- Compare: SLT op_a = 0xFFFFFFFF, op_b = 1 -> 1. SLTU same operands -> 0.
- Shifts, iterative: SRA 0x80000000 by op_b = 0x24 (shamt 4) -> out_valid cycle 4, result 0xF8000000. SLL shamt 0 -> cycle 1, op_a unchanged. With ALU_FAST_SHIFT_EN the same SRA -> cycle 1.
- Backpressure: hold out_ready = 0 for 3 cycles after out_valid -> result stable, in_ready = 0, in_valid ignored. out_ready = 1 -> IDLE next cycle, in_ready = 1.
- Flush: SLL 1 by 20 accepted cycle 0, flush at cycle 5 -> no out_valid, in_ready = 1 at cycle 6. A new ADD 1 + 1 accepted then -> result 2.
- Reset mid-shift: rst asserted cycle 3 of SRL by 10 -> next cycle out_valid = 0, result = 0, in_ready = 1. Illegal aluctr 4'hF -> result 0 at cycle 1.
